// File: rtl/dfr_reservoir_ctrl.sv
// Delayed-feedback reservoir: per input sample, steps VIRTUAL_NODES virtual nodes (mask, feedback, nonlinearity).
// Node j of a sample accepted on edge t is valid after edge t+1+j; a stalled dout freezes all stepping.

module mackey_glass_block #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_x,
  output logic [DATA_WIDTH-1:0] o_y
);
  // Soft saturation y = x - x*|x|/2^DW: odd, monotonic, never overflows DATA_WIDTH.
  logic [DATA_WIDTH-1:0]          w_abs;
  logic signed [2*DATA_WIDTH-1:0] w_sq;
  logic [DATA_WIDTH-1:0]          w_corr;

  assign w_abs  = i_x[DATA_WIDTH-1] ? DATA_WIDTH'(-i_x) : i_x;
  assign w_sq   = $signed(i_x) * $signed({1'b0, w_abs});
  assign w_corr = w_sq[2*DATA_WIDTH-1:DATA_WIDTH];
  assign o_y    = i_x - w_corr;
endmodule

module dfr_reservoir_ctrl #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int MASK_WIDTH    = 16,
  parameter int FRAC_BITS     = 8,
  localparam int PW           = $clog2(VIRTUAL_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [PW-1:0]         dout_node,
  output logic                  dout_last,
  input  logic                  mask_we,
  input  logic [PW-1:0]         mask_addr,
  input  logic [MASK_WIDTH-1:0] mask_data,
  input  logic [4:0]            fb_shift,
  input  logic                  nl_bypass,
  input  logic                  clear,
  output logic                  busy
);
  localparam int PRW = DATA_WIDTH + MASK_WIDTH;
  localparam logic [PW-1:0] LAST_NODE = PW'(VIRTUAL_NODES - 1);
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;

  state_t                        r_state, w_state_nxt;
  logic [PW-1:0]                 r_ptr, w_ptr_nxt;
  logic signed [DATA_WIDTH-1:0]  r_u;
  logic signed [DATA_WIDTH-1:0]  r_delay [VIRTUAL_NODES];
  logic signed [MASK_WIDTH-1:0]  r_mask  [VIRTUAL_NODES];
  logic [DATA_WIDTH-1:0]         r_dout;
  logic                          r_dout_valid;
  logic [PW-1:0]                 r_dout_node;
  logic                          r_dout_last;

  logic                          w_step, w_accept, w_clr_wr;
  logic signed [PRW-1:0]         w_prod, w_prod_sh;
  logic [MASK_WIDTH:0]           w_hi;
  logic [DATA_WIDTH-1:0]         w_m, w_s, w_nl, w_x;
  logic signed [DATA_WIDTH-1:0]  w_f;
  logic [DATA_WIDTH:0]           w_sum;

  // A step may only overwrite dout when the previous value is gone or leaving now.
  assign w_step = (r_state == S_RUN) && !(r_dout_valid && !dout_ready);

  assign w_prod    = r_u * r_mask[r_ptr];
  assign w_prod_sh = w_prod >>> FRAC_BITS;
  assign w_hi      = w_prod_sh[PRW-1:DATA_WIDTH-1];
  assign w_m       = (&w_hi || !(|w_hi)) ? w_prod_sh[DATA_WIDTH-1:0]
                                         : (w_prod_sh[PRW-1] ? SMIN : SMAX);
  assign w_f       = r_delay[r_ptr] >>> fb_shift;
  assign w_sum     = {w_m[DATA_WIDTH-1], w_m} + {w_f[DATA_WIDTH-1], w_f};
  assign w_s       = (w_sum[DATA_WIDTH] == w_sum[DATA_WIDTH-1]) ? w_sum[DATA_WIDTH-1:0]
                                                                : (w_sum[DATA_WIDTH] ? SMIN : SMAX);

  mackey_glass_block #(.DATA_WIDTH(DATA_WIDTH)) u_mg (
    .i_x (w_s),
    .o_y (w_nl)
  );

  assign w_x = nl_bypass ? w_s : w_nl;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    din_ready   = 1'b0;
    w_accept    = 1'b0;
    w_clr_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        din_ready = !clear;
        if (clear) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end else if (din_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
          w_ptr_nxt   = '0;
        end
      end
      S_RUN: begin
        if (w_step) begin
          if (r_ptr == LAST_NODE) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + PW'(1);
          end
        end
      end
      S_CLEAR: begin
        w_clr_wr = 1'b1;
        if (r_ptr == LAST_NODE) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + PW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_u     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_accept) r_u <= din;
    end
  end

  // Delay entry j is read and rewritten in the same step: it holds node j of the previous sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VIRTUAL_NODES; i++) begin
        r_delay[i] <= '0;
        r_mask[i]  <= '0;
      end
    end else begin
      if (w_step)
        r_delay[r_ptr] <= w_x;
      else if (w_clr_wr)
        r_delay[r_ptr] <= '0;
      if (mask_we && (r_state == S_IDLE))
        r_mask[mask_addr] <= mask_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_node  <= '0;
      r_dout_last  <= 1'b0;
    end else if (w_step) begin
      r_dout       <= w_x;
      r_dout_valid <= 1'b1;
      r_dout_node  <= r_ptr;
      r_dout_last  <= (r_ptr == LAST_NODE);
    end else if (dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_node  = r_dout_node;
  assign dout_last  = r_dout_last;
  assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_dfr_reservoir_ctrl.sv
// Directed bench for dfr_reservoir_ctrl with N=4, DW=16, FRAC_BITS=8; expected values computed by hand.
module tb_dfr_reservoir_ctrl;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [1:0]           dout_node;
  logic                 dout_last;
  logic                 mask_we;
  logic [1:0]           mask_addr;
  logic [MW-1:0]        mask_data;
  logic [4:0]           fb_shift;
  logic                 nl_bypass;
  logic                 clear;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dfr_reservoir_ctrl #(
    .VIRTUAL_NODES (N),
    .DATA_WIDTH    (DW),
    .MASK_WIDTH    (MW),
    .FRAC_BITS     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_node  (dout_node),
    .dout_last  (dout_last),
    .mask_we    (mask_we),
    .mask_addr  (mask_addr),
    .mask_data  (mask_data),
    .fb_shift   (fb_shift),
    .nl_bypass  (nl_bypass),
    .clear      (clear),
    .busy       (busy)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr_mask(input int a, input int d);
    mask_we   = 1'b1;
    mask_addr = 2'(a);
    mask_data = 16'(d);
    @(negedge clk);
    mask_we   = 1'b0;
  endtask

  task automatic set_masks(input int m0, input int m1, input int m2, input int m3);
    wr_mask(0, m0);
    wr_mask(1, m1);
    wr_mask(2, m2);
    wr_mask(3, m3);
  endtask

  task automatic send(input int u, input bit poke);
    bit done = 1'b0;
    din       = 16'(u);
    din_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (din_ready) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
    if (poke) begin
      mask_we   = 1'b1;
      mask_addr = 2'd1;
      mask_data = '0;
      clear     = 1'b1;
    end
  endtask

  task automatic collect(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp_v[4];
    int k   = 0;
    int cyc = 0;
    exp_v = '{e0, e1, e2, e3};
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      mask_we = 1'b0;
      clear   = 1'b0;
      cyc++;
      if (dout_valid) begin
        check($sformatf("%s_n%0d_val", name, k), dout, exp_v[k]);
        check($sformatf("%s_n%0d_idx", name, k), dout_node, k);
        check($sformatf("%s_n%0d_last", name, k), dout_last, (k == N-1));
        check($sformatf("%s_n%0d_lat", name, k), cyc, k + 1);
        k++;
      end
    end
    if (k < 4) check($sformatf("%s_timeout", name), k, 4);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    check("clear_done_busy", busy, 0);
  endtask

  initial begin
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    mask_we    = 1'b0;
    mask_addr  = '0;
    mask_data  = '0;
    fb_shift   = 5'd1;
    nl_bypass  = 1'b1;
    clear      = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_node", dout_node, 0);
    check("rst_last", dout_last, 0);
    check("rst_busy", busy, 0);
    check("rst_din_ready", din_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Unity masks, half feedback: decays 100 -> 50 -> 25
    set_masks(256, 256, 256, 256);
    send(100, 0);
    collect("t1", 100, 100, 100, 100);
    send(0, 0);
    collect("t2a", 50, 50, 50, 50);
    send(0, 0);
    collect("t2b", 25, 25, 25, 25);

    // clear beats a simultaneous din_valid; busy for exactly 4 cycles
    clear     = 1'b1;
    din       = 16'sd999;
    din_valid = 1'b1;
    #1;
    check("clr_din_ready", din_ready, 0);
    @(negedge clk);
    clear     = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clr_busy%0d", i), busy, 1);
      check($sformatf("clr_novalid%0d", i), dout_valid, 0);
      @(negedge clk);
    end
    check("clr_idle", busy, 0);

    // Mixed masks; mask write and clear attempted during RUN must be ignored
    set_masks(256, -256, 128, 0);
    send(64, 1);
    collect("t3", 64, -64, 32, 0);

    // Saturation at both rails with full feedback
    do_clear();
    fb_shift = 5'd0;
    set_masks(256, 256, 256, 256);
    send(32767, 0);
    collect("t4a", 32767, 32767, 32767, 32767);
    send(32767, 0);
    collect("t4b", 32767, 32767, 32767, 32767);
    send(-32768, 0);
    collect("t4c", -1, -1, -1, -1);
    send(-32768, 0);
    collect("t4d", -32768, -32768, -32768, -32768);

    // Nonlinearity: 16384 - 16384*16384/65536 = 12288
    do_clear();
    fb_shift  = 5'd31;
    nl_bypass = 1'b0;
    send(16384, 0);
    collect("nl", 12288, 12288, 12288, 12288);
    nl_bypass = 1'b1;

    // Backpressure: hold node 1 for three cycles
    do_clear();
    fb_shift = 5'd1;
    set_masks(256, 512, 768, 1024);
    send(10, 0);
    @(negedge clk);
    check("bp_n0_val", dout, 10);
    check("bp_n0_idx", dout_node, 0);
    @(negedge clk);
    check("bp_n1_val", dout, 20);
    check("bp_n1_idx", dout_node, 1);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_val", i), dout, 20);
      check($sformatf("bp_hold%0d_idx", i), dout_node, 1);
      check($sformatf("bp_hold%0d_vld", i), dout_valid, 1);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp_n2_val", dout, 30);
    check("bp_n2_idx", dout_node, 2);
    @(negedge clk);
    check("bp_n3_val", dout, 40);
    check("bp_n3_idx", dout_node, 3);
    check("bp_n3_last", dout_last, 1);

    // Reset mid-RUN; delay holds 10,20,30,40 so node 2 = 100 + 30/2
    set_masks(256, 256, 256, 256);
    send(100, 0);
    repeat (3) @(negedge clk);
    check("mr_n2_val", dout, 115);
    check("mr_n2_idx", dout_node, 2);
    rst = 1'b0;
    #1;
    check("mr_dout", dout, 0);
    check("mr_valid", dout_valid, 0);
    check("mr_node", dout_node, 0);
    check("mr_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_post_valid", dout_valid, 0);
    set_masks(256, 256, 256, 256);
    send(100, 0);
    collect("t6", 100, 100, 100, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench timed out");
  end
endmodule
